aemb2_dmem_lsu: RTL and testbench

Load/store unit in the EX→MX slot, directly downstream of the integer unit.
- Consumes the registered effective word address mem_ex and the opcode/store operand from operand fetch.
- Drives the Wishbone-style data bus and produces byte-lane-aligned load data for writeback in MX.
- Back-pressures the pipeline through dwb_fb, which the top level ANDs into dena.

---
 rtl/aemb2_pkg.sv | 22 ++
 rtl/aemb2_dmem_align.sv | 51 +++++
 rtl/aemb2_dmem_lsu.sv | 172 +++++++++++++++++
 tb/tb_aemb2_dmem_lsu.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aemb2_pkg.sv
// Shared definitions for the AEMB2 data-memory load/store path: transfer
// size encodings, the load/store opcode group and the LSU state encoding.
package aemb2_pkg;

    // Transfer size as carried in opc_of[1:0]
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // opc_of[5:4] value that marks a load/store instruction
    localparam logic [1:0] LSU_OPC = 2'b11;

    // opc_of[2] set marks a store
    localparam int OPC_ST_BIT = 2;

    // LSU bus state
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/aemb2_dmem_align.sv
// Byte-lane alignment for a 32-bit big-endian bus: lane selects from size
// and address low bits, store-data replication, and load-data extraction
// driven by the lane selects of the access in flight.
module aemb2_dmem_align
    import aemb2_pkg::*;
(
    input  logic [1:0]  sz_i,     // size of the access being issued
    input  logic [1:0]  lo_i,     // byte offset of the access being issued
    input  logic [31:0] wdat_i,   // raw store operand
    input  logic [3:0]  rsel_i,   // lane selects of the access in flight
    input  logic [31:0] rdat_i,   // raw bus read data
    output logic [3:0]  sel_o,    // lane selects for the access being issued
    output logic [31:0] wdat_o,   // store data replicated across lanes
    output logic [31:0] rdat_o    // selected lane moved to LSBs, zero-extended
);

    // Lane selects: bit3 is bus bits [31:24] (lowest byte address)
    always_comb begin
        sel_o = 4'b1111;
        case (sz_i)
            SZ_BYTE: sel_o = 4'b1000 >> lo_i;
            SZ_HALF: sel_o = lo_i[1] ? 4'b0011 : 4'b1100;
            default: sel_o = 4'b1111;
        endcase
    end

    // Replicate the operand so the addressed lane carries it whatever lo is
    always_comb begin
        wdat_o = wdat_i;
        case (sz_i)
            SZ_BYTE: wdat_o = {4{wdat_i[7:0]}};
            SZ_HALF: wdat_o = {2{wdat_i[15:0]}};
            default: wdat_o = wdat_i;
        endcase
    end

    // Pick the lane(s) the registered selects point at and zero-extend
    always_comb begin
        rdat_o = rdat_i;
        case (rsel_i)
            4'b1000: rdat_o = {24'd0, rdat_i[31:24]};
            4'b0100: rdat_o = {24'd0, rdat_i[23:16]};
            4'b0010: rdat_o = {24'd0, rdat_i[15:8]};
            4'b0001: rdat_o = {24'd0, rdat_i[7:0]};
            4'b1100: rdat_o = {16'd0, rdat_i[31:16]};
            4'b0011: rdat_o = {16'd0, rdat_i[15:0]};
            default: rdat_o = rdat_i;
        endcase
    end

endmodule

// File: rtl/aemb2_dmem_lsu.sv
// AEMB2 load/store unit in the EX->MX slot. Captures the load/store kind on
// pipeline advance, issues one Wishbone-style request per memory op, holds
// the bus until ack, and returns aligned load data in lod_mx.
// Optional bus timeout: define AEMB2_DWB_TIMEOUT_EN to abandon a transfer
// after AEMB_DTO un-acked BUSY cycles and raise the sticky dwb_err flag.
//
// Handshake: a request is live while dwb_stb_o=1; address, data, selects and
// write enable are stable until the cycle dwb_ack_i=1, which completes it.
// dwb_fb=1 means the pipeline may advance this cycle.
module aemb2_dmem_lsu
    import aemb2_pkg::*;
#(
    parameter int AEMB_DWB = 32,
    parameter int AEMB_DTO = 255
) (
    input  logic                gclk,
    input  logic                grst,
    input  logic                dena,
    input  logic [5:0]          opc_of,
    input  logic [31:0]         opd_of,
    input  logic [AEMB_DWB-3:0] mem_ex,
    input  logic [1:0]          adr_lo_ex,
    output logic [AEMB_DWB-3:0] dwb_adr_o,
    output logic [31:0]         dwb_dat_o,
    output logic [3:0]          dwb_sel_o,
    output logic                dwb_stb_o,
    output logic                dwb_cyc_o,
    output logic                dwb_wre_o,
    input  logic [31:0]         dwb_dat_i,
    input  logic                dwb_ack_i,
    output logic                dwb_fb,
    output logic                dwb_err,
    output logic [31:0]         lod_mx,
    output lsu_state_e          dbg_state_o
);

    // EX-stage copy of the op captured from OF
    logic                ex_mem_q;
    logic                ex_st_q;
    logic [1:0]          ex_sz_q;
    logic [31:0]         ex_dat_q;

    // Bus-side registers
    lsu_state_e          state_q;
    logic [AEMB_DWB-3:0] adr_q;
    logic [31:0]         dat_q;
    logic [3:0]          sel_q;
    logic                stb_q;
    logic                wre_q;
    logic [31:0]         lod_q;

    logic [3:0]          iss_sel;
    logic [31:0]         iss_dat;
    logic [31:0]         ld_ext;
    logic                of_is_mem;
    logic                issue;
    logic                tmo_hit;

    // opc_of[3] carries no meaning for the LSU
    logic                unused_opc;
    assign unused_opc = opc_of[3];

    assign of_is_mem = (opc_of[5:4] == LSU_OPC);

    // A memory op in EX goes out on the edge the pipeline advances, either
    // from IDLE or straight out of the ack cycle of the previous transfer.
    assign issue = dena & ex_mem_q & ((state_q == IDLE) | dwb_ack_i);

    aemb2_dmem_align u_align (
        .sz_i   (ex_sz_q),
        .lo_i   (adr_lo_ex),
        .wdat_i (ex_dat_q),
        .rsel_i (sel_q),
        .rdat_i (dwb_dat_i),
        .sel_o  (iss_sel),
        .wdat_o (iss_dat),
        .rdat_o (ld_ext)
    );

    // Capture op kind and store operand from OF when the pipeline advances
    always_ff @(posedge gclk) begin
        if (grst) begin
            ex_mem_q <= 1'b0;
            ex_st_q  <= 1'b0;
            ex_sz_q  <= SZ_BYTE;
            ex_dat_q <= 32'd0;
        end else if (dena) begin
            ex_mem_q <= of_is_mem;
            ex_st_q  <= opc_of[OPC_ST_BIT];
            ex_sz_q  <= opc_of[1:0];
            ex_dat_q <= opd_of;
        end
    end

    // Bus FSM with registered request outputs and load result
    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            wre_q   <= 1'b0;
            adr_q   <= '0;
            sel_q   <= 4'd0;
            dat_q   <= 32'd0;
            lod_q   <= 32'd0;
        end else begin
            if (issue) begin
                state_q <= BUSY;
                stb_q   <= 1'b1;
                wre_q   <= ex_st_q;
                adr_q   <= mem_ex;
                sel_q   <= iss_sel;
                dat_q   <= iss_dat;
            end else if ((state_q == BUSY) && (dwb_ack_i || tmo_hit)) begin
                state_q <= IDLE;
                stb_q   <= 1'b0;
            end

            if ((state_q == BUSY) && dwb_ack_i && !wre_q) begin
                lod_q <= ld_ext;
            end else if (tmo_hit && !wre_q) begin
                lod_q <= 32'hFFFF_FFFF;
            end
        end
    end

`ifdef AEMB2_DWB_TIMEOUT_EN
    localparam logic [7:0] DTO_LAST = 8'(AEMB_DTO - 1);

    logic [7:0] tmo_cnt_q;
    logic       err_q;

    // The last permitted wait cycle without ack abandons the transfer
    assign tmo_hit = (state_q == BUSY) & ~dwb_ack_i & (tmo_cnt_q == DTO_LAST);

    // Count un-acked BUSY cycles; the error flag stays set until reset
    always_ff @(posedge gclk) begin
        if (grst) begin
            tmo_cnt_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            if (issue) begin
                tmo_cnt_q <= 8'd0;
            end else if ((state_q == BUSY) && !dwb_ack_i) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign dwb_err = err_q;
`else
    localparam int UNUSED_DTO = AEMB_DTO;

    assign tmo_hit = 1'b0;
    assign dwb_err = 1'b0;
`endif

    // Stall only while a transfer is waiting; ack and timeout cycles release
    assign dwb_fb      = ~((state_q == BUSY) & ~dwb_ack_i) | tmo_hit;

    assign dwb_adr_o   = adr_q;
    assign dwb_dat_o   = dat_q;
    assign dwb_sel_o   = sel_q;
    assign dwb_stb_o   = stb_q;
    assign dwb_cyc_o   = stb_q;
    assign dwb_wre_o   = wre_q;
    assign lod_mx      = lod_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aemb2_dmem_lsu.sv
// Self-checking bench for aemb2_dmem_lsu. The bench plays both the pipeline
// (OF/EX operands, dena gated by dwb_fb as the top level does) and the bus
// slave. Expected values come from arithmetic lane rules on byte addresses.
// With AEMB2_DWB_TIMEOUT_EN defined the timeout scenario is exercised too.
module tb_aemb2_dmem_lsu;
    import aemb2_pkg::*;

`ifdef AEMB2_DWB_TIMEOUT_EN
    localparam int TB_DTO = 4;
`else
    localparam int TB_DTO = 255;
`endif

    logic        gclk;
    logic        grst;
    logic        dena;
    logic        dena_req;
    logic [5:0]  opc_of;
    logic [31:0] opd_of;
    logic [29:0] mem_ex;
    logic [1:0]  adr_lo_ex;
    logic [29:0] dwb_adr_o;
    logic [31:0] dwb_dat_o;
    logic [3:0]  dwb_sel_o;
    logic        dwb_stb_o;
    logic        dwb_cyc_o;
    logic        dwb_wre_o;
    logic [31:0] dwb_dat_i;
    logic        dwb_ack_i;
    logic        dwb_fb;
    logic        dwb_err;
    logic [31:0] lod_mx;
    lsu_state_e  dbg_state_o;

    int          total;
    int          bad;
    logic [31:0] exp_lod;
    logic        exp_err;

    aemb2_dmem_lsu #(
        .AEMB_DWB (32),
        .AEMB_DTO (TB_DTO)
    ) dut (
        .gclk        (gclk),
        .grst        (grst),
        .dena        (dena),
        .opc_of      (opc_of),
        .opd_of      (opd_of),
        .mem_ex      (mem_ex),
        .adr_lo_ex   (adr_lo_ex),
        .dwb_adr_o   (dwb_adr_o),
        .dwb_dat_o   (dwb_dat_o),
        .dwb_sel_o   (dwb_sel_o),
        .dwb_stb_o   (dwb_stb_o),
        .dwb_cyc_o   (dwb_cyc_o),
        .dwb_wre_o   (dwb_wre_o),
        .dwb_dat_i   (dwb_dat_i),
        .dwb_ack_i   (dwb_ack_i),
        .dwb_fb      (dwb_fb),
        .dwb_err     (dwb_err),
        .lod_mx      (lod_mx),
        .dbg_state_o (dbg_state_o)
    );

    // The pipeline only advances when the LSU allows it
    assign dena = dena_req & dwb_fb;

    // Clock
    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    // Reference rules, byte-address arithmetic
    function automatic logic [3:0] ref_sel(input int sz, input int lo);
        if (sz == 0) return 4'(8 >> lo);
        if (sz == 1) return (lo >= 2) ? 4'h3 : 4'hC;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdat(input int sz, input logic [31:0] d);
        if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_lod(input int sz, input int lo, input logic [31:0] d);
        if (sz == 0) return (d >> (8 * (3 - lo))) & 32'hFF;
        if (sz == 1) return (d >> ((lo >= 2) ? 0 : 16)) & 32'hFFFF;
        return d;
    endfunction

    function automatic logic [5:0] mem_opc(input bit st, input int sz);
        return {2'b11, 1'b0, st, 2'(sz)};
    endfunction

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    // One isolated access: OF -> EX -> request -> waits -> ack
    task automatic do_access(input bit st, input int sz, input logic [31:0] addr,
                             input logic [31:0] opd, input logic [31:0] rdat,
                             input int waits, input string tag);
        int lo;
        lo = int'(addr[1:0]);
        dwb_ack_i = 1'b0;
        opc_of = mem_opc(st, sz); opd_of = opd; dena_req = 1'b1;
        tick();
        opc_of = 6'h00; opd_of = $urandom; mem_ex = addr[31:2]; adr_lo_ex = addr[1:0];
        tick();
        mem_ex = 30'($urandom); adr_lo_ex = 2'($urandom);
        total++; if (dwb_stb_o !== 1'b1 || dwb_cyc_o !== 1'b1) begin bad++; $display("FAIL %s stb/cyc: got %b/%b want 1/1", tag, dwb_stb_o, dwb_cyc_o); end
        total++; if (dwb_adr_o !== addr[31:2]) begin bad++; $display("FAIL %s adr: got %h want %h", tag, dwb_adr_o, addr[31:2]); end
        total++; if (dwb_sel_o !== ref_sel(sz, lo)) begin bad++; $display("FAIL %s sel: got %b want %b", tag, dwb_sel_o, ref_sel(sz, lo)); end
        total++; if (dwb_wre_o !== st) begin bad++; $display("FAIL %s wre: got %b want %b", tag, dwb_wre_o, st); end
        if (st) begin
            total++; if (dwb_dat_o !== ref_wdat(sz, opd)) begin bad++; $display("FAIL %s dat: got %h want %h", tag, dwb_dat_o, ref_wdat(sz, opd)); end
        end
        for (int w = 0; w < waits; w++) begin
            total++; if (dwb_fb !== 1'b0 || dwb_stb_o !== 1'b1) begin bad++; $display("FAIL %s wait%0d fb/stb: got %b/%b want 0/1", tag, w, dwb_fb, dwb_stb_o); end
            tick();
        end
        dwb_ack_i = 1'b1; dwb_dat_i = rdat;
        #1;
        total++; if (dwb_fb !== 1'b1) begin bad++; $display("FAIL %s ack fb: got %b want 1", tag, dwb_fb); end
        tick();
        dwb_ack_i = 1'b0; dwb_dat_i = $urandom;
        if (!st) exp_lod = ref_lod(sz, lo, rdat);
        total++; if (dwb_stb_o !== 1'b0) begin bad++; $display("FAIL %s stb after ack: got %b want 0", tag, dwb_stb_o); end
        total++; if (lod_mx !== exp_lod) begin bad++; $display("FAIL %s lod_mx: got %h want %h", tag, lod_mx, exp_lod); end
        total++; if (dwb_err !== exp_err) begin bad++; $display("FAIL %s err: got %b want %b", tag, dwb_err, exp_err); end
    endtask

    task automatic test_reset();
        logic [31:0] a;
        grst = 1'b1; dena_req = 1'b0; opc_of = 6'h00; opd_of = 32'd0;
        mem_ex = 30'd0; adr_lo_ex = 2'd0; dwb_ack_i = 1'b0; dwb_dat_i = 32'd0;
        tick(); tick();
        total++; if (dwb_stb_o !== 1'b0 || dwb_cyc_o !== 1'b0 || dwb_wre_o !== 1'b0) begin bad++; $display("FAIL reset stb/cyc/wre: got %b%b%b want 000", dwb_stb_o, dwb_cyc_o, dwb_wre_o); end
        total++; if (dwb_adr_o !== 30'd0 || dwb_sel_o !== 4'd0 || dwb_dat_o !== 32'd0) begin bad++; $display("FAIL reset adr/sel/dat: got %h/%b/%h want 0", dwb_adr_o, dwb_sel_o, dwb_dat_o); end
        total++; if (lod_mx !== 32'd0 || dwb_err !== 1'b0 || dwb_fb !== 1'b1) begin bad++; $display("FAIL reset lod/err/fb: got %h/%b/%b want 0/0/1", lod_mx, dwb_err, dwb_fb); end
        total++; if (dbg_state_o !== IDLE) begin bad++; $display("FAIL reset state: got %0d want IDLE", dbg_state_o); end
        grst = 1'b0;
        exp_lod = 32'd0; exp_err = 1'b0;
        // make lod_mx non-zero so the mid-transaction reset has something to clear
        do_access(1'b0, 2, {$urandom} & 32'hFFFF_FFFC, 32'd0, $urandom | 32'h0101_0101, 0, "rst_pre");
        a = $urandom;
        opc_of = mem_opc(1'b0, 2); dena_req = 1'b1;
        tick();
        opc_of = 6'h00; mem_ex = a[31:2]; adr_lo_ex = 2'd0;
        tick();
        total++; if (dwb_stb_o !== 1'b1) begin bad++; $display("FAIL rst_busy stb: got %b want 1", dwb_stb_o); end
        grst = 1'b1; dwb_ack_i = 1'b1; dwb_dat_i = 32'hCAFE_F00D;
        tick();
        grst = 1'b0; dena_req = 1'b0;
        total++; if (dwb_stb_o !== 1'b0 || dwb_cyc_o !== 1'b0) begin bad++; $display("FAIL rst_mid stb/cyc: got %b/%b want 0/0", dwb_stb_o, dwb_cyc_o); end
        total++; if (lod_mx !== 32'd0) begin bad++; $display("FAIL rst_mid lod_mx: got %h want 00000000", lod_mx); end
        total++; if (dbg_state_o !== IDLE) begin bad++; $display("FAIL rst_mid state: got %0d want IDLE", dbg_state_o); end
        tick();
        total++; if (dwb_stb_o !== 1'b0 || lod_mx !== 32'd0) begin bad++; $display("FAIL rst_ack stb/lod: got %b/%h want 0/00000000", dwb_stb_o, lod_mx); end
        dwb_ack_i = 1'b0; dena_req = 1'b1;
        exp_lod = 32'd0;
    endtask

    task automatic test_directed();
        do_access(1'b1, 2, 32'h0000_1004, 32'hDEAD_BEEF, 32'd0, 3, "word_st");
        do_access(1'b0, 0, 32'h0000_0002, 32'd0, 32'h1122_3344, 0, "byte_ld");
        do_access(1'b1, 1, 32'h0000_2002, 32'h0000_ABCD, 32'd0, 1, "half_st");
        do_access(1'b0, 1, 32'h0000_2000, 32'd0, 32'hABCD_0000, 0, "half_ld");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_access(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom, $urandom,
                      $urandom, $urandom_range(0, 3), "rand");
        end
    endtask

    task automatic test_nonmem_and_stall();
        logic [31:0] a;
        logic [31:0] r;
        for (int i = 0; i < 6; i++) begin
            opc_of = {2'($urandom_range(0, 2)), 4'($urandom)}; opd_of = $urandom;
            mem_ex = 30'($urandom); adr_lo_ex = 2'($urandom); dena_req = 1'b1;
            tick();
            total++; if (dwb_stb_o !== 1'b0 || lod_mx !== exp_lod) begin bad++; $display("FAIL nonmem stb/lod: got %b/%h want 0/%h", dwb_stb_o, lod_mx, exp_lod); end
        end
        // op sitting in OF with dena low is not captured
        opc_of = mem_opc(1'b0, 2); dena_req = 1'b0;
        tick(); tick();
        total++; if (dwb_stb_o !== 1'b0) begin bad++; $display("FAIL stall_of stb: got %b want 0", dwb_stb_o); end
        // captured into EX, then held with dena low: still no request
        a = $urandom; r = $urandom;
        dena_req = 1'b1;
        tick();
        opc_of = 6'h00; dena_req = 1'b0; mem_ex = a[31:2]; adr_lo_ex = a[1:0];
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (dwb_stb_o !== 1'b0) begin bad++; $display("FAIL stall_ex%0d stb: got %b want 0", i, dwb_stb_o); end
        end
        dena_req = 1'b1;
        tick();
        total++; if (dwb_stb_o !== 1'b1 || dwb_adr_o !== a[31:2]) begin bad++; $display("FAIL stall_go stb/adr: got %b/%h want 1/%h", dwb_stb_o, dwb_adr_o, a[31:2]); end
        dwb_ack_i = 1'b1; dwb_dat_i = r;
        tick();
        dwb_ack_i = 1'b0;
        exp_lod = r;
        total++; if (dwb_stb_o !== 1'b0 || lod_mx !== exp_lod) begin bad++; $display("FAIL stall_done stb/lod: got %b/%h want 0/%h", dwb_stb_o, lod_mx, exp_lod); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            int sz1, sz2, w1, w2;
            logic [31:0] a1, a2, d1, d2;
            sz1 = $urandom_range(0, 2); sz2 = $urandom_range(0, 2);
            w1 = $urandom_range(0, 2); w2 = $urandom_range(0, 2);
            a1 = $urandom; a2 = $urandom; d1 = $urandom; d2 = $urandom;
            dwb_ack_i = 1'b0; dena_req = 1'b1;
            opc_of = mem_opc(1'b0, sz1);
            tick();
            opc_of = mem_opc(1'b0, sz2); mem_ex = a1[31:2]; adr_lo_ex = a1[1:0];
            tick();
            opc_of = 6'h00; mem_ex = a2[31:2]; adr_lo_ex = a2[1:0];
            total++; if (dwb_stb_o !== 1'b1 || dwb_adr_o !== a1[31:2] || dwb_sel_o !== ref_sel(sz1, int'(a1[1:0]))) begin bad++; $display("FAIL b2b first stb/adr/sel: got %b/%h/%b want 1/%h/%b", dwb_stb_o, dwb_adr_o, dwb_sel_o, a1[31:2], ref_sel(sz1, int'(a1[1:0]))); end
            for (int w = 0; w < w1; w++) begin
                tick();
                total++; if (dwb_stb_o !== 1'b1) begin bad++; $display("FAIL b2b wait1 stb: got %b want 1", dwb_stb_o); end
            end
            dwb_ack_i = 1'b1; dwb_dat_i = d1;
            tick();
            exp_lod = ref_lod(sz1, int'(a1[1:0]), d1);
            dwb_ack_i = 1'b0;
            total++; if (dwb_stb_o !== 1'b1 || dwb_adr_o !== a2[31:2] || dwb_sel_o !== ref_sel(sz2, int'(a2[1:0]))) begin bad++; $display("FAIL b2b second stb/adr/sel: got %b/%h/%b want 1/%h/%b", dwb_stb_o, dwb_adr_o, dwb_sel_o, a2[31:2], ref_sel(sz2, int'(a2[1:0]))); end
            total++; if (lod_mx !== exp_lod) begin bad++; $display("FAIL b2b lod1: got %h want %h", lod_mx, exp_lod); end
            for (int w = 0; w < w2; w++) begin
                tick();
                total++; if (dwb_stb_o !== 1'b1) begin bad++; $display("FAIL b2b wait2 stb: got %b want 1", dwb_stb_o); end
            end
            dwb_ack_i = 1'b1; dwb_dat_i = d2;
            tick();
            exp_lod = ref_lod(sz2, int'(a2[1:0]), d2);
            dwb_ack_i = 1'b0;
            total++; if (dwb_stb_o !== 1'b0 || lod_mx !== exp_lod) begin bad++; $display("FAIL b2b lod2 stb/lod: got %b/%h want 0/%h", dwb_stb_o, lod_mx, exp_lod); end
        end
    endtask

`ifdef AEMB2_DWB_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] a;
        a = $urandom;
        dwb_ack_i = 1'b0; dena_req = 1'b1;
        opc_of = mem_opc(1'b0, 2);
        tick();
        opc_of = 6'h00; mem_ex = a[31:2]; adr_lo_ex = a[1:0];
        tick();
        for (int c = 0; c < TB_DTO; c++) begin
            total++; if (dwb_stb_o !== 1'b1) begin bad++; $display("FAIL tmo cyc%0d stb: got %b want 1", c, dwb_stb_o); end
            total++; if (dwb_fb !== (c == TB_DTO - 1)) begin bad++; $display("FAIL tmo cyc%0d fb: got %b want %b", c, dwb_fb, (c == TB_DTO - 1)); end
            tick();
        end
        exp_lod = 32'hFFFF_FFFF; exp_err = 1'b1;
        total++; if (dwb_stb_o !== 1'b0 || dwb_cyc_o !== 1'b0) begin bad++; $display("FAIL tmo drop stb/cyc: got %b/%b want 0/0", dwb_stb_o, dwb_cyc_o); end
        total++; if (lod_mx !== exp_lod || dwb_err !== exp_err) begin bad++; $display("FAIL tmo lod/err: got %h/%b want %h/1", lod_mx, dwb_err, exp_lod); end
        do_access(1'b0, $urandom_range(0, 2), $urandom, 32'd0, $urandom, 2, "tmo_after");
        do_access(1'b1, 2, $urandom, $urandom, 32'd0, 0, "tmo_after_st");
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_directed();
        test_random();
        test_nonmem_and_stall();
        test_back_to_back();
`ifdef AEMB2_DWB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
